// File: rtl/spi_slave.sv
// SPI mode 0 target: pins are oversampled in the clock domain and bridged to word source/sink pulses.
// Latency: pin edge to action 3 cycles with synchronizers (1 without); MISO updates one cycle after the action.
// Backpressure: none; the sink must take every put, and an empty source makes the slave shift out FILL.
//
// Ports:
//   clock, reset_n        system clock, synchronous active-low reset
//   in / get / empty      transmit word source; get is a one-cycle pulse that consumes in
//   out / put             received word sink; out is valid while put is high and holds afterwards
//   spi_cs_n, spi_clock,
//   spi_mosi, spi_miso    SPI mode 0 pins (CPOL=0, CPHA=0, MSB first)
//
// Build option: define SPI_SLAVE_SYNC_EN to put 2-flop synchronizers on the SPI input pins.
// Without it the pins feed the edge detectors directly, which is only safe for same-clock benches.

module spi_slave #(
    parameter int           W    = 8,
    parameter logic [W-1:0] FILL = {W{1'b1}}
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso
);

    localparam int            CW   = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // {cs_n, sck, mosi}; idle levels are cs high, sck low
    localparam logic [2:0] PIN_IDLE = 3'b100;

    logic [2:0] pins;
    logic [2:0] cur;
    assign pins = {spi_cs_n, spi_clock, spi_mosi};

`ifdef SPI_SLAVE_SYNC_EN
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cur = sync2_q;
`else
    assign cur = pins;
`endif

    state_t        state_q, state_d;
    logic [1:0]    prev_q, prev_d;     // previous {cs_n, sck} for edge detection
    logic [1:0]    warm_q, warm_d;     // fills with ones once the input pipe holds real pin values
    logic          armed_q, armed_d;   // cs seen high since reset; blocks a restart mid-frame
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;     // a word completed on the last sck rise
    logic [W-1:0]  rx_q, rx_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  out_q, out_d;
    logic          put_q, put_d;
    logic          miso_q, miso_d;

    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic load;

    assign cs_fall  =  prev_q[1] & ~cur[2];
    assign cs_rise  = ~prev_q[1] &  cur[2];
    assign sck_rise = ~prev_q[0] &  cur[1];
    assign sck_fall =  prev_q[0] & ~cur[1];

    always_comb begin
        state_d = state_q;
        prev_d  = cur[2:1];
        warm_d  = {warm_q[0], 1'b1};
        armed_d = armed_q | (warm_q[1] & cur[2]);
        cnt_d   = cnt_q;
        done_d  = done_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        out_d   = out_q;
        put_d   = 1'b0;
        load    = 1'b0;
        get     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                done_d = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                // cs_rise takes priority over any coincident sck edge
                if (cs_rise) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_d = {rx_q[W-2:0], cur[0]};
                    if (cnt_q == LAST) begin
                        out_d  = rx_d;
                        put_d  = 1'b1;
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    // done distinguishes a finished word from a frame with no rise yet
                    if (done_q) begin
                        load   = 1'b1;
                        done_d = 1'b0;
                    end else if (cnt_q != '0) begin
                        tx_d = {tx_q[W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (!empty) begin
                tx_d = in;
                get  = reset_n;
            end else begin
                tx_d = FILL;
            end
        end

        miso_d = (state_q == ACTIVE) ? tx_q[W-1] : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            prev_q  <= PIN_IDLE[2:1];
            warm_q  <= '0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rx_q    <= '0;
            tx_q    <= FILL;
            out_q   <= '0;
            put_q   <= 1'b0;
            miso_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            out_q   <= out_d;
            put_q   <= put_d;
            miso_q  <= miso_d;
        end
    end

    assign out      = out_q;
    assign put      = put_q;
    assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bench-side SPI master drives mode 0 frames with hand-computed data.
// Latency: expected strobe latency depends on whether SPI_SLAVE_SYNC_EN is defined.
// Backpressure: the bench source is a small word list; get pops it, put is always accepted.

module tb_spi_slave;

`ifdef SPI_SLAVE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int HALF = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_clock = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       get, put;
    logic [7:0] out;
    logic [7:0] src_word;
    logic       src_empty;

    logic [7:0] src_mem [0:7];
    int         src_n = 0;
    int         src_rd = 0;
    bit         pop_pend = 0;

    int         cyc = 0;
    int         get_cnt = 0, put_cnt = 0;
    int         get_cyc = 0, put_cyc = 0;
    int         cs_cyc = 0, rise_cyc = 0;
    logic [7:0] put_log [0:15];

    int         n_checks = 0;
    int         n_fail = 0;

    assign src_empty = (src_rd >= src_n);
    assign src_word  = src_mem[src_rd[2:0]];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    spi_slave #(.W(8), .FILL(8'hFF)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in       (src_word),
        .get      (get),
        .empty    (src_empty),
        .out      (out),
        .put      (put),
        .spi_cs_n (spi_cs_n),
        .spi_clock(spi_clock),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    // get/put observed mid-cycle; the source advances just after the consuming edge
    always @(negedge clock) begin
        if (get === 1'b1) begin
            get_cnt++;
            get_cyc  = cyc;
            pop_pend = 1;
        end
        if (put === 1'b1) begin
            if (put_cnt < 16) put_log[put_cnt] = out;
            put_cnt++;
            put_cyc = cyc;
        end
    end

    always @(posedge clock) begin
        if (pop_pend) begin
            #1;
            src_rd++;
            pop_pend = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_src(input logic [7:0] w);
        src_mem[src_n[2:0]] = w;
        src_n++;
    endtask

    task automatic cs_down();
        cs_cyc   = cyc;
        spi_cs_n = 1'b0;
        wait_cyc(6);
    endtask

    task automatic cs_up();
        spi_cs_n = 1'b1;
        wait_cyc(8);
    endtask

    // MOSI changes with the falling edge, MISO is sampled just before each rising edge
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            wait_cyc(HALF);
            mi        = {mi[6:0], spi_miso};
            rise_cyc  = cyc;
            spi_clock = 1'b1;
            wait_cyc(HALF);
            spi_clock = 1'b0;
        end
    endtask

    logic [7:0] rx, rx2;
    int         g0, p0, d;

    initial begin
        // reset with pins toggling
        for (int i = 0; i < 3; i++) begin
            spi_cs_n  = i[0];
            spi_clock = ~i[0];
            spi_mosi  = 1'b1;
            wait_cyc(1);
        end
        @(negedge clock);
        chk("rst_miso", {31'd0, spi_miso}, 32'd1);
        chk("rst_put",  {31'd0, put},      32'd0);
        chk("rst_get",  {31'd0, get},      32'd0);
        chk("rst_out",  {24'd0, out},      32'd0);
        wait_cyc(1);
        spi_cs_n  = 1'b1;
        spi_clock = 1'b0;
        spi_mosi  = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(8);

        // single word
        push_src(8'hA5);
        g0 = get_cnt; p0 = put_cnt;
        cs_down();
        xfer(8'h3C, 8, rx);
        cs_up();
        chk("single_miso", {24'd0, rx}, 32'hA5);
        chk("single_gets", get_cnt - g0, 32'd1);
        d = get_cyc - cs_cyc;
        chk("single_get_lat", {31'd0, (d >= LAT - 1) && (d <= LAT)}, 32'd1);
        chk("single_puts", put_cnt - p0, 32'd1);
        chk("single_put_lat", put_cyc - rise_cyc, LAT);
        chk("single_out", {24'd0, put_log[p0]}, 32'h3C);

        // back-to-back words with cs held low
        push_src(8'h10);
        push_src(8'h20);
        g0 = get_cnt; p0 = put_cnt;
        cs_down();
        xfer(8'h01, 8, rx);
        xfer(8'h02, 8, rx2);
        cs_up();
        chk("b2b_rx0", {24'd0, rx},  32'h10);
        chk("b2b_rx1", {24'd0, rx2}, 32'h20);
        chk("b2b_gets", get_cnt - g0, 32'd2);
        chk("b2b_put0", {24'd0, put_log[p0]},     32'h01);
        chk("b2b_put1", {24'd0, put_log[p0 + 1]}, 32'h02);

        // empty source shifts FILL
        g0 = get_cnt; p0 = put_cnt;
        cs_down();
        xfer(8'h55, 8, rx);
        cs_up();
        chk("empty_rx", {24'd0, rx}, 32'hFF);
        chk("empty_gets", get_cnt - g0, 32'd0);
        chk("empty_out", {24'd0, out}, 32'h55);

        // abort after five bits, then a full frame
        p0 = put_cnt;
        cs_down();
        xfer(8'h9A, 5, rx);
        cs_up();
        chk("abort_puts", put_cnt - p0, 32'd0);
        chk("abort_out", {24'd0, out}, 32'h55);
        cs_down();
        xfer(8'hC3, 8, rx);
        cs_up();
        chk("after_abort_puts", put_cnt - p0, 32'd1);
        chk("after_abort_out", {24'd0, out}, 32'hC3);

        // reset pulse in the middle of a frame
        p0 = put_cnt;
        cs_down();
        xfer(8'hF0, 3, rx);
        reset_n = 1'b0;
        wait_cyc(1);
        reset_n = 1'b1;
        wait_cyc(2);
        chk("midrst_miso", {31'd0, spi_miso}, 32'd1);
        xfer(8'hF0, 5, rx);
        chk("midrst_tail_miso", {27'd0, rx[4:0]}, 32'h1F);
        cs_up();
        chk("midrst_puts", put_cnt - p0, 32'd0);
        chk("midrst_out", {24'd0, out}, 32'h00);
        push_src(8'h96);
        g0 = get_cnt;
        cs_down();
        xfer(8'h7E, 8, rx);
        cs_up();
        chk("post_rst_rx", {24'd0, rx}, 32'h96);
        chk("post_rst_out", {24'd0, out}, 32'h7E);
        chk("post_rst_gets", get_cnt - g0, 32'd1);
        chk("post_rst_puts", put_cnt - p0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode 0 target (CPOL=0, CPHA=0, MSB first) that receives words from an external SPI master and shifts reply words back. It oversamples the SPI pins in the system clock domain. It bridges the pins to the same word-stream handshakes the bit-bang SPI master uses: a source port (`in`/`get`/`empty`) for transmit data and a sink port (`out`/`put`) for received data. It sits on the device side of the bit-bang SPI link and is the counterpart of `spi_master`.

## Interface
- `W`, 8: word width in bits, minimum 2.
- `FILL`, all ones (`{W{1'b1}}`): word shifted out when the source is empty at load time.
- `clock` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: synchronous reset, active-low.
- `in` in W: transmit word from the source; valid while `empty` = 0.
- `get` out 1: one-cycle pulse; consumes `in` in the same cycle.
- `empty` in 1: source has no word.
- `out` out W: last received word; holds between updates.
- `put` out 1: one-cycle pulse; `out` is valid in the same cycle.
- `spi_cs_n` in 1: chip select, active-low, asynchronous to `clock`.
- `spi_clock` in 1: SPI clock, idle low, asynchronous to `clock`.
- `spi_mosi` in 1: master-out data.
- `spi_miso` out 1: slave-out data.

## Operation
- **Input stage:** `spi_cs_n`, `spi_clock` and `spi_mosi` each pass through a 2-flop synchronizer. A third register per line holds the previous synced value for edge detection. This yields `cs_fall`, `cs_rise`, `sck_rise` and `sck_fall` single-cycle strobes.
- **States:**
  - IDLE: `spi_miso` = 1, bit count = 0.
  - ACTIVE: frame in progress.
- **IDLE → ACTIVE** on `cs_fall`. In the same cycle, load the tx shift register:
  - `empty` = 0: load `in` and pulse `get`.
  - `empty` = 1: load `FILL`; no `get`.
- **ACTIVE, `sck_rise`:**
  - Shift the synced MOSI into the LSB of the rx register.
  - Bit count +1.
  - At count W: `out` <= assembled word, pulse `put`, count <= 0.
- **ACTIVE, `sck_fall`:**
  - Count ≠ 0: shift tx left by one.
  - Count = 0 (a word just completed): reload tx from the source by the same rule as at `cs_fall`. This covers back-to-back words with CS held low.
- **`spi_miso`:** equals tx MSB while ACTIVE.
- **ACTIVE → IDLE** on `cs_rise`:
  - A partial rx word is discarded; no `put`.
  - Count <= 0.
  - A partially sent tx word is dropped; it is not re-queued.
- **`sck_fall` with no preceding `sck_rise` in the frame:** ignored, count stays 0.
- **`cs_rise` with a coincident `sck_rise`/`sck_fall`:** `cs_rise` wins; the edge is ignored.
- **Edges while IDLE:** ignored.
- **Counter:** bit count is ceil(log2(W+1)) bits wide and never exceeds W.

## Timing
- **Reset values** (`reset_n` low at a rising edge): `out` = 0, `put` = 0, `get` = 0, `spi_miso` = 1, state IDLE, count 0, synchronizers and edge registers = idle pin levels (cs 1, sck 0).
- **Reset mid-frame** aborts the frame as `cs_rise` does. A frame starts again only on a new `cs_fall` after reset is released.
- **Pin-to-strobe latency:** 3 `clock` cycles with synchronizers.
- **`put`:** asserted 3 cycles after the W-th SPI rising edge; high for exactly 1 cycle.
- **`get`:** asserted 3 cycles after the CS falling edge, or after the W-th SPI falling edge.
- **`spi_miso` update:** registered; changes 4 cycles after the SPI falling edge (or CS fall) that causes it.
- **Constraints on the master:**
  - SPI half-period ≥ 4 `clock` cycles.
  - Setup from CS fall to first SCK rise ≥ 5 cycles.
  - CS high time ≥ 4 cycles.
  - Under these constraints, MISO is stable before every SPI rising edge.
- **Handshake rules:**
  - `get` and `put` may be high in the same cycle only if their strobes coincide; this cannot happen in mode 0 and is not required.
  - The sink must accept `put` unconditionally.

## Configuration
- **`SPI_SLAVE_SYNC_EN` defined:** 2-flop synchronizers are present; pin-to-strobe latency is 3 cycles, as specified above.
- **`SPI_SLAVE_SYNC_EN` undefined:**
  - Pins feed the edge-detect registers directly; pin-to-strobe latency is 1 cycle.
  - All latencies above shrink by 2.
  - The SPI half-period minimum drops to 2 cycles.
  - Intended only for same-clock benches, for example looped to `spi_master`.

## Test plan
- **Reset:** hold `reset_n` = 0 for 3 cycles with pins toggling -> `spi_miso` = 1, `put` = `get` = 0, `out` = 0.
- **Single word:** source holds 8'hA5; master sends 8'h3C with half-period 4 -> one `get` 3 cycles after CS fall; MISO bits 1,0,1,0,0,1,0,1 sampled at SCK rises; one `put` with `out` = 8'h3C.
- **Back-to-back:** source holds 8'h10, 8'h20; master sends 8'h01, 8'h02 without raising CS -> master reads 8'h10, 8'h20; `put` pulses with 8'h01 then 8'h02; exactly 2 `get` pulses.
- **Empty source:** `empty` = 1; master sends 8'h55 -> master reads 8'hFF (FILL); `get` never asserted; `out` = 8'h55.
- **Abort:** CS raised after 5 SCK rises -> no `put`, `out` unchanged. The next full frame with 8'hC3 -> `put`, `out` = 8'hC3.
- **Reset mid-frame:** `reset_n` low for 1 cycle after bit 3 -> `spi_miso` = 1 and no `put`. A new CS frame exchanges correctly.
